dne_axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank for the DNE searcher IP, succeeding the fixed four-register slave interface. It provides NUM_REGS software-visible registers with byte-strobe writes, per-register read-only status slots, and SLVERR on illegal accesses. It also emits one-cycle write pulses to the searcher core. It sits between the AXI interconnect and the searcher datapath.

---
 rtl/dne_axil_pkg.sv | 25 ++
 rtl/dne_axil_regbank_if.sv | 44 ++++
 rtl/dne_axil_wr_ctrl.sv | 119 +++++++++++
 rtl/dne_axil_regbank.sv | 145 ++++++++++++++
 tb/tb_dne_axil_regbank.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dne_axil_pkg.sv
// Shared types and helpers for the DNE searcher AXI4-Lite register bank.
package dne_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_HAVE_ADDR = 2'd1,
      W_HAVE_DATA = 2'd2,
      W_RESP      = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_VALID = 1'b1
   } rd_state_e;

   // Word index of a byte address; lsb is log2 of the bus width in bytes.
   function automatic int unsigned addr_to_index(input logic [63:0] addr,
                                                 input int unsigned lsb);
      return 32'(addr >> lsb);
   endfunction

endpackage

// File: rtl/dne_axil_regbank_if.sv
// AXI4-Lite bundle between the interconnect and the register bank.
interface dne_axil_regbank_if #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );

endinterface

// File: rtl/dne_axil_wr_ctrl.sv
// Write-side FSM: pairs AW and W in any order, raises a commit strobe on the
// completing edge and produces the B response.
module dne_axil_wr_ctrl
   import dne_axil_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 6,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [ADDR_W-1:0]                       awaddr,
   input  logic                                    awvalid,
   output logic                                    awready,
   input  logic [DATA_W-1:0]                       wdata,
   input  logic [DATA_W/8-1:0]                     wstrb,
   input  logic                                    wvalid,
   output logic                                    wready,
   output logic [1:0]                              bresp,
   output logic                                    bvalid,
   input  logic                                    bready,
   output logic                                    commit_c,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0]      commit_index_c,
   output logic [DATA_W-1:0]                       commit_data_c,
   output logic [DATA_W/8-1:0]                     commit_strb_c
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_W - LSB;

   wr_state_e          state_q;
   logic [ADDR_W-1:0]  aw_addr_q;
   logic [DATA_W-1:0]  w_data_q;
   logic [STRB_W-1:0]  w_strb_q;

   logic               aw_hs_c;
   logic               w_hs_c;
   logic               pair_done_c;
   logic               legal_c;
   logic [ADDR_W-1:0]  addr_c;
   logic [IDX_W-1:0]   idx_c;

   // Channel readiness follows the state; both are held low during reset.
   assign awready = rst_n && ((state_q == W_IDLE) || (state_q == W_HAVE_DATA));
   assign wready  = rst_n && ((state_q == W_IDLE) || (state_q == W_HAVE_ADDR));

   assign aw_hs_c = awvalid && awready;
   assign w_hs_c  = wvalid && wready;

   // Merge the held half of the transaction with the live channel.
   assign addr_c        = (state_q == W_HAVE_ADDR) ? aw_addr_q : awaddr;
   assign commit_data_c = (state_q == W_HAVE_DATA) ? w_data_q  : wdata;
   assign commit_strb_c = (state_q == W_HAVE_DATA) ? w_strb_q  : wstrb;
   assign idx_c         = IDX_W'(addr_to_index(64'(addr_c), LSB));

   // The pair completes when the missing handshake arrives.
   always_comb begin
      pair_done_c = 1'b0;
      case (state_q)
         W_IDLE:      pair_done_c = aw_hs_c && w_hs_c;
         W_HAVE_ADDR: pair_done_c = w_hs_c;
         W_HAVE_DATA: pair_done_c = aw_hs_c;
         W_RESP:      pair_done_c = 1'b0;
      endcase
   end

   // Only in-range, writable registers accept a commit.
   always_comb begin
      legal_c = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if ((idx_c == IDX_W'(i)) && !RO_MASK[i]) begin
            legal_c = 1'b1;
         end
      end
   end

   assign commit_c       = pair_done_c && legal_c;
   assign commit_index_c = idx_c;

   // Write FSM with holding registers and the registered B channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= W_IDLE;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
      end else if (pair_done_c) begin
         state_q <= W_RESP;
         bvalid  <= 1'b1;
         bresp   <= legal_c ? RESP_OKAY : RESP_SLVERR;
      end else begin
         case (state_q)
            W_IDLE: begin
               if (aw_hs_c) begin
                  aw_addr_q <= awaddr;
                  state_q   <= W_HAVE_ADDR;
               end else if (w_hs_c) begin
                  w_data_q <= wdata;
                  w_strb_q <= wstrb;
                  state_q  <= W_HAVE_DATA;
               end
            end
            W_HAVE_ADDR: state_q <= W_HAVE_ADDR;
            W_HAVE_DATA: state_q <= W_HAVE_DATA;
            W_RESP: begin
               if (bready) begin
                  bvalid  <= 1'b0;
                  state_q <= W_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/dne_axil_regbank.sv
// AXI4-Lite register bank for the DNE searcher: read/write registers with
// byte strobes, read-only status slots, SLVERR on illegal accesses and
// per-register write pulses towards the core.
module dne_axil_regbank
   import dne_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
   parameter int unsigned NUM_REGS           = 6,
   parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
   input  logic                                   S_AXI_ACLK,
   input  logic                                   S_AXI_ARESETN,
   dne_axil_regbank_if.slave                      s_axi,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
   output logic [NUM_REGS-1:0]                    wr_pulse
);

   localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned STRB_W = DW / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = AW - LSB;

   logic [NUM_REGS-1:0][DW-1:0] regs_q;

   logic                commit_c;
   logic [IDX_W-1:0]    commit_index_c;
   logic [DW-1:0]       commit_data_c;
   logic [STRB_W-1:0]   commit_strb_c;

   rd_state_e           r_state_q;
   logic [DW-1:0]       rdata_q;
   logic [1:0]          rresp_q;
   logic                rvalid_q;
   logic [IDX_W-1:0]    rd_idx_c;
   logic [DW-1:0]       rd_data_c;
   logic                rd_err_c;

   // Protection bits carry no meaning for this slave.
   logic unused_prot_c;
   assign unused_prot_c = ^{s_axi.awprot, s_axi.arprot};

   dne_axil_wr_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .NUM_REGS (NUM_REGS),
      .RO_MASK  (RO_MASK)
   ) u_wr_ctrl (
      .clk            (S_AXI_ACLK),
      .rst_n          (S_AXI_ARESETN),
      .awaddr         (s_axi.awaddr),
      .awvalid        (s_axi.awvalid),
      .awready        (s_axi.awready),
      .wdata          (s_axi.wdata),
      .wstrb          (s_axi.wstrb),
      .wvalid         (s_axi.wvalid),
      .wready         (s_axi.wready),
      .bresp          (s_axi.bresp),
      .bvalid         (s_axi.bvalid),
      .bready         (s_axi.bready),
      .commit_c       (commit_c),
      .commit_index_c (commit_index_c),
      .commit_data_c  (commit_data_c),
      .commit_strb_c  (commit_strb_c)
   );

   // Byte-strobed update of the addressed register on a legal commit.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         regs_q <= '0;
      end else if (commit_c) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (commit_index_c == IDX_W'(i)) begin
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (commit_strb_c[b]) begin
                     regs_q[i][b*8 +: 8] <= commit_data_c[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   assign reg_out = regs_q;

   // One-cycle pulse following each legal commit.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_pulse <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wr_pulse[i] <= commit_c && (commit_index_c == IDX_W'(i));
         end
      end
   end

   // Read source: status slice for RO slots, register contents otherwise.
   always_comb begin
      rd_idx_c  = IDX_W'(addr_to_index(64'(s_axi.araddr), LSB));
      rd_data_c = '0;
      rd_err_c  = 1'b1;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (rd_idx_c == IDX_W'(i)) begin
            rd_err_c  = 1'b0;
            rd_data_c = RO_MASK[i] ? status_in[i*DW +: DW] : regs_q[i];
         end
      end
   end

   assign s_axi.arready = S_AXI_ARESETN && (r_state_q == R_IDLE);

   // Read FSM: capture on AR handshake, hold until RREADY.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (s_axi.arvalid) begin
                  rdata_q   <= rd_data_c;
                  rresp_q   <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
                  rvalid_q  <= 1'b1;
                  r_state_q <= R_VALID;
               end
            end
            R_VALID: begin
               if (s_axi.rready) begin
                  rvalid_q  <= 1'b0;
                  r_state_q <= R_IDLE;
               end
            end
         endcase
      end
   end

   assign s_axi.rdata  = rdata_q;
   assign s_axi.rresp  = rresp_q;
   assign s_axi.rvalid = rvalid_q;

endmodule

// File: tb/tb_dne_axil_regbank.sv
// Directed bench for dne_axil_regbank: table of write/read vectors plus
// hand-written sequences for ordering, strobes, backpressure and reset.
module tb_dne_axil_regbank;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;
   localparam int unsigned NR = 6;
   localparam logic [NR-1:0] ROM = 6'b100000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR*DW-1:0] reg_out;
   logic [NR*DW-1:0] status_in;
   logic [NR-1:0]    wr_pulse;

   dne_axil_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

   dne_axil_regbank #(
      .C_S_AXI_DATA_WIDTH (DW),
      .C_S_AXI_ADDR_WIDTH (AW),
      .NUM_REGS           (NR),
      .RO_MASK            (ROM)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (axi.slave),
      .reg_out       (reg_out),
      .status_in     (status_in),
      .wr_pulse      (wr_pulse)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int pulse_cnt [NR] = '{default: 0};

   // Count pulses mid-cycle so each one-cycle strobe is seen exactly once.
   always @(negedge clk) begin
      for (int i = 0; i < int'(NR); i++) begin
         if (wr_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done = 0;
      bit w_done = 0;
      bit aw_go, w_go;
      int c = 0;
      resp = 2'bxx;
      while (!(aw_done && w_done) && c < 50) begin
         @(negedge clk);
         axi.awaddr  = addr;
         axi.wdata   = data;
         axi.wstrb   = strb;
         axi.awvalid = !aw_done;
         axi.wvalid  = !w_done;
         aw_go = axi.awvalid && axi.awready;
         w_go  = axi.wvalid && axi.wready;
         @(posedge clk); #1;
         if (aw_go) begin aw_done = 1; axi.awvalid = 1'b0; end
         if (w_go)  begin w_done = 1;  axi.wvalid  = 1'b0; end
         c++;
      end
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      if (!(aw_done && w_done)) check("aw_w_handshake_timeout", 0, 1);
      axi.bready = 1'b1;
      c = 0;
      while (c < 50) begin
         @(negedge clk);
         if (axi.bvalid) begin
            resp = axi.bresp;
            @(posedge clk); #1;
            break;
         end
         c++;
      end
      axi.bready = 1'b0;
      if (c >= 50) check("b_timeout", 0, 1);
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit ar_go = 0;
      int c = 0;
      data = 'x;
      resp = 2'bxx;
      while (!ar_go && c < 50) begin
         @(negedge clk);
         axi.araddr  = addr;
         axi.arvalid = 1'b1;
         ar_go = axi.arready;
         @(posedge clk); #1;
         c++;
      end
      axi.arvalid = 1'b0;
      if (!ar_go) check("ar_timeout", 0, 1);
      axi.rready = 1'b1;
      c = 0;
      while (c < 50) begin
         @(negedge clk);
         if (axi.rvalid) begin
            data = axi.rdata;
            resp = axi.rresp;
            @(posedge clk); #1;
            break;
         end
         c++;
      end
      axi.rready = 1'b0;
      if (c >= 50) check("r_timeout", 0, 1);
   endtask

   typedef struct {
      bit          is_wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
      string       name;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [31:0] exp_slice [NR];

      vecs[0]  = '{1'b1, 6'h00, 32'h1,        4'hF, 2'b00, 32'h0,    "wr_reg0"};
      vecs[1]  = '{1'b1, 6'h04, 32'h2,        4'hF, 2'b00, 32'h0,    "wr_reg1"};
      vecs[2]  = '{1'b1, 6'h08, 32'h3,        4'hF, 2'b00, 32'h0,    "wr_reg2"};
      vecs[3]  = '{1'b1, 6'h0C, 32'h4,        4'hF, 2'b00, 32'h0,    "wr_reg3"};
      vecs[4]  = '{1'b0, 6'h00, 32'h0,        4'h0, 2'b00, 32'h1,    "rd_reg0"};
      vecs[5]  = '{1'b0, 6'h04, 32'h0,        4'h0, 2'b00, 32'h2,    "rd_reg1"};
      vecs[6]  = '{1'b0, 6'h08, 32'h0,        4'h0, 2'b00, 32'h3,    "rd_reg2"};
      vecs[7]  = '{1'b0, 6'h0C, 32'h0,        4'h0, 2'b00, 32'h4,    "rd_reg3"};
      vecs[8]  = '{1'b1, 6'h14, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,    "wr_ro_reg5"};
      vecs[9]  = '{1'b1, 6'h18, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,    "wr_out_of_range"};
      vecs[10] = '{1'b0, 6'h14, 32'h0,        4'h0, 2'b00, 32'h5A5A, "rd_ro_reg5"};
      vecs[11] = '{1'b0, 6'h18, 32'h0,        4'h0, 2'b10, 32'h0,    "rd_out_of_range"};

      axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
      axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
      axi.bready = 1'b0;
      axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;
      status_in = {32'h00005A5A, 32'hBAD00004, 32'hBAD00003,
                   32'hBAD00002, 32'hBAD00001, 32'hBAD00000};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_awready", axi.awready, 0);
      check("rst_wready",  axi.wready,  0);
      check("rst_arready", axi.arready, 0);
      check("rst_bvalid",  axi.bvalid,  0);
      check("rst_rvalid",  axi.rvalid,  0);
      check("rst_bresp",   axi.bresp,   0);
      check("rst_rresp",   axi.rresp,   0);
      check("rst_rdata",   axi.rdata,   0);
      check("rst_wr_pulse", wr_pulse,   0);
      check("rst_reg_out_lo", reg_out[63:0], 0);
      rst_n = 1'b1;
      #1;
      check("post_rst_awready", axi.awready, 1);
      check("post_rst_wready",  axi.wready,  1);
      check("post_rst_arready", axi.arready, 1);

      // Table of simultaneous-channel writes and reads
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            check({vecs[i].name, "_bresp"}, resp, vecs[i].exp_resp);
         end else begin
            axi_read(vecs[i].addr, rd, resp);
            check({vecs[i].name, "_rresp"}, resp, vecs[i].exp_resp);
            check({vecs[i].name, "_rdata"}, rd,   vecs[i].exp_rdata);
         end
      end
      for (int i = 0; i < int'(NR); i++) begin
         check($sformatf("pulse_count_reg%0d", i), pulse_cnt[i], (i < 4) ? 1 : 0);
      end
      exp_slice = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h0, 32'h0};
      for (int i = 0; i < int'(NR); i++) begin
         check($sformatf("reg_out_slice%0d", i), reg_out[i*32 +: 32], exp_slice[i]);
      end

      // W leads AW by three cycles
      @(negedge clk);
      axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      check("wfirst_wready_before", axi.wready, 1);
      @(posedge clk); #1;
      axi.wvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("wfirst_wready_held", axi.wready, 0);
         check("wfirst_bvalid_early", axi.bvalid, 0);
      end
      @(negedge clk);
      axi.awaddr = 6'h10; axi.awvalid = 1'b1;
      check("wfirst_awready", axi.awready, 1);
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      check("wfirst_bvalid", axi.bvalid, 1);
      check("wfirst_bresp", axi.bresp, 0);
      check("wfirst_reg4", reg_out[4*32 +: 32], 32'hDEADBEEF);
      @(negedge clk);
      check("wfirst_pulse", wr_pulse, 6'b010000);
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      @(negedge clk);
      check("wfirst_bvalid_done", axi.bvalid, 0);
      check("wfirst_pulse_gone", wr_pulse, 0);

      // Partial strobe: bytes 0 and 2 take the new data
      axi_write(6'h04, 32'h11223344, 4'hF, resp);
      check("strb_full_bresp", resp, 0);
      axi_write(6'h04, 32'hAABBCCDD, 4'b0101, resp);
      check("strb_part_bresp", resp, 0);
      check("strb_reg1", reg_out[1*32 +: 32], 32'h11BB33DD);
      axi_read(6'h04, rd, resp);
      check("strb_rd_reg1", rd, 32'h11BB33DD);

      // BREADY withheld on an SLVERR response
      @(negedge clk);
      axi.awaddr = 6'h18; axi.awvalid = 1'b1;
      axi.wdata = 32'h12345678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_bvalid",  axi.bvalid,  1);
         check("bp_bresp",   axi.bresp,   2'b10);
         check("bp_awready", axi.awready, 0);
         check("bp_wready",  axi.wready,  0);
      end
      axi.bready = 1'b1;
      @(posedge clk); #1;
      axi.bready = 1'b0;
      @(negedge clk);
      check("bp_bvalid_done", axi.bvalid, 0);
      check("bp_no_pulse", wr_pulse, 0);
      check("bp_reg4_kept", reg_out[4*32 +: 32], 32'hDEADBEEF);

      // Reset while an address is held
      @(negedge clk);
      axi.awaddr = 6'h00; axi.awvalid = 1'b1;
      @(posedge clk); #1;
      axi.awvalid = 1'b0;
      @(negedge clk);
      check("mid_have_addr_awready", axi.awready, 0);
      check("mid_have_addr_wready",  axi.wready,  1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_awready", axi.awready, 0);
      check("mid_rst_wready",  axi.wready,  0);
      check("mid_rst_reg_out", (reg_out == '0), 1);
      @(negedge clk);
      rst_n = 1'b1;
      status_in[5*32 +: 32] = 32'h0;
      #1;
      check("mid_rel_awready", axi.awready, 1);
      check("mid_rel_wready",  axi.wready,  1);
      repeat (4) begin
         @(negedge clk);
         check("mid_rel_no_bvalid", axi.bvalid, 0);
      end
      for (int i = 0; i < int'(NR); i++) begin
         axi_read(6'(i * 4), rd, resp);
         check($sformatf("mid_rel_rd_reg%0d", i), rd, 0);
         check($sformatf("mid_rel_rresp%0d", i), resp, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
